// File: rtl/spi_command_executor_pkg.sv
// Shared command codes, payload sizes and the draw-request record used by
// the SPI command executor and its draw-request FIFO.
package spi_command_executor_pkg;

  localparam logic [7:0] COMMAND_SAVE_SPRITE = 8'h53;
  localparam logic [7:0] COMMAND_DRAW_SPRITE = 8'h44;
  localparam int         SPRITE_BYTES        = 512;
  localparam int         DRAW_BYTES          = 6;

  typedef struct packed {
    logic [7:0]  sprite;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  flags;
  } draw_req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE_ID,
    ST_SAVE_PIX,
    ST_DRAW_ASM,
    ST_SKIP
  } exec_state_t;

endpackage

// File: rtl/spi_command_executor_fifo.sv
// Synchronous draw-request FIFO: power-of-two depth, head read straight from
// storage so a push into an empty FIFO is visible the next cycle.
module draw_req_fifo
  import spi_command_executor_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push,
  input  draw_req_t push_data,
  input  logic      ready,
  output logic      valid,
  output draw_req_t head,
  output logic      full
);

  localparam int PW = $clog2(DEPTH);

  draw_req_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     count;
  logic            do_push, do_pop;

  assign valid   = (count != '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign head    = mem[rd_ptr];
  assign do_pop  = valid & ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_command_executor.sv
// Turns parsed SPI bytes into sprite-RAM writes and queued draw requests.
// Define SPI_EXEC_STATS_EN to add saturating write/draw/drop counters.
module spi_command_executor
  import spi_command_executor_pkg::*;
#(
  parameter int SPRITE_COUNT = 64,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              frame_end,
  input  logic                              in_byte,
  input  logic [7:0]                        in_command,
  input  logic [7:0]                        in_data,
  input  logic [15:0]                       in_index,
  output logic                              spr_we,
  output logic [$clog2(SPRITE_COUNT)+8:0]   spr_addr,
  output logic [7:0]                        spr_wdata,
  output logic                              draw_valid,
  input  logic                              draw_ready,
  output logic [7:0]                        draw_sprite,
  output logic [15:0]                       draw_x,
  output logic [15:0]                       draw_y,
  output logic [7:0]                        draw_flags,
  output logic                              draw_overflow
`ifdef SPI_EXEC_STATS_EN
  ,
  output logic [15:0]                       stat_writes,
  output logic [15:0]                       stat_draws,
  output logic [7:0]                        stat_drops
`endif
);

  localparam int          ID_W     = $clog2(SPRITE_COUNT);
  localparam logic [15:0] LAST_PIX = 16'(SPRITE_BYTES + 1);
  localparam logic [15:0] LAST_DRW = 16'(DRAW_BYTES);

  exec_state_t        state, state_n;
  logic               byte_q;
  logic [15:0]        exp_idx, exp_n;
  logic [ID_W-1:0]    save_id, id_n;
  draw_req_t          asm_q, asm_n, push_req, head;
  logic               we_n;
  logic [ID_W+8:0]    addr_n;
  logic [7:0]         wdata_n;
  logic [8:0]         pix;
  logic               push, fifo_full, pop, drop;

  assign pix  = in_index[8:0] - 9'd2;
  assign pop  = draw_valid & draw_ready;
  assign drop = push & fifo_full & ~pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      byte_q        <= 1'b0;
      exp_idx       <= '0;
      save_id       <= '0;
      asm_q         <= '0;
      spr_we        <= 1'b0;
      spr_addr      <= '0;
      spr_wdata     <= '0;
      draw_overflow <= 1'b0;
    end else begin
      state     <= state_n;
      byte_q    <= in_byte;
      exp_idx   <= exp_n;
      save_id   <= id_n;
      asm_q     <= asm_n;
      spr_we    <= we_n;
      spr_addr  <= addr_n;
      spr_wdata <= wdata_n;
      if (drop) draw_overflow <= 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    exp_n    = exp_idx;
    id_n     = save_id;
    asm_n    = asm_q;
    we_n     = 1'b0;
    addr_n   = spr_addr;
    wdata_n  = spr_wdata;
    push     = 1'b0;
    push_req = asm_q;
    push_req.flags = in_data;
    // frame_end wins over a byte decoded in the same cycle.
    if (frame_end) begin
      state_n = ST_IDLE;
    end else if (byte_q) begin
      if (in_index == 16'd0) begin
        exp_n = 16'd1;
        case (in_command)
          COMMAND_SAVE_SPRITE: state_n = ST_SAVE_ID;
          COMMAND_DRAW_SPRITE: begin
            state_n = ST_DRAW_ASM;
            asm_n   = '0;
          end
          default:             state_n = ST_IDLE;
        endcase
      end else begin
        exp_n = exp_idx + 16'd1;
        // Out-of-sequence bytes abort the command with no side effect.
        if (in_index != exp_idx &&
            (state == ST_SAVE_ID || state == ST_SAVE_PIX || state == ST_DRAW_ASM)) begin
          state_n = ST_IDLE;
        end else begin
          case (state)
            ST_SAVE_ID: begin
              id_n    = in_data[ID_W-1:0];
              state_n = ({24'd0, in_data} < 32'(SPRITE_COUNT)) ? ST_SAVE_PIX : ST_SKIP;
            end
            ST_SAVE_PIX: begin
              we_n    = 1'b1;
              addr_n  = {save_id, pix};
              wdata_n = in_data;
              if (in_index == LAST_PIX) state_n = ST_IDLE;
            end
            ST_DRAW_ASM: begin
              case (in_index)
                16'd1:   asm_n.sprite   = in_data;
                16'd2:   asm_n.x[15:8]  = in_data;
                16'd3:   asm_n.x[7:0]   = in_data;
                16'd4:   asm_n.y[15:8]  = in_data;
                16'd5:   asm_n.y[7:0]   = in_data;
                default: begin
                  if (in_index == LAST_DRW) begin
                    push    = 1'b1;
                    state_n = ST_IDLE;
                  end
                end
              endcase
            end
            default: state_n = state;
          endcase
        end
      end
    end
  end

  draw_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_req),
    .ready     (draw_ready),
    .valid     (draw_valid),
    .head      (head),
    .full      (fifo_full)
  );

  assign draw_sprite = head.sprite;
  assign draw_x      = head.x;
  assign draw_y      = head.y;
  assign draw_flags  = head.flags;

`ifdef SPI_EXEC_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_writes <= '0;
      stat_draws  <= '0;
      stat_drops  <= '0;
    end else begin
      if (spr_we && stat_writes != '1)                    stat_writes <= stat_writes + 1'b1;
      if (push && !drop && stat_draws != '1)              stat_draws  <= stat_draws + 1'b1;
      if (drop && stat_drops != '1)                       stat_drops  <= stat_drops + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_command_executor.sv
// Directed bench for spi_command_executor; optional counter checks follow
// the same SPI_EXEC_STATS_EN macro as the design.
module tb_spi_command_executor;
  import spi_command_executor_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_end = 1'b0;
  logic        in_byte = 1'b0;
  logic [7:0]  in_command = '0;
  logic [7:0]  in_data = '0;
  logic [15:0] in_index = '0;
  logic        spr_we;
  logic [14:0] spr_addr;
  logic [7:0]  spr_wdata;
  logic        draw_valid;
  logic        draw_ready = 1'b0;
  logic [7:0]  draw_sprite;
  logic [15:0] draw_x, draw_y;
  logic [7:0]  draw_flags;
  logic        draw_overflow;
`ifdef SPI_EXEC_STATS_EN
  logic [15:0] stat_writes, stat_draws;
  logic [7:0]  stat_drops;
`endif

  spi_command_executor #(.SPRITE_COUNT(64), .FIFO_DEPTH(8)) dut (
    .clock         (clock),
    .reset         (reset),
    .frame_end     (frame_end),
    .in_byte       (in_byte),
    .in_command    (in_command),
    .in_data       (in_data),
    .in_index      (in_index),
    .spr_we        (spr_we),
    .spr_addr      (spr_addr),
    .spr_wdata     (spr_wdata),
    .draw_valid    (draw_valid),
    .draw_ready    (draw_ready),
    .draw_sprite   (draw_sprite),
    .draw_x        (draw_x),
    .draw_y        (draw_y),
    .draw_flags    (draw_flags),
    .draw_overflow (draw_overflow)
`ifdef SPI_EXEC_STATS_EN
    ,
    .stat_writes   (stat_writes),
    .stat_draws    (stat_draws),
    .stat_drops    (stat_drops)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: pixels are always sent as 0..FF repeating from exp_base.
  int          wr_cnt = 0, wr_start = 0, wr_bad = 0;
  logic [14:0] exp_base = '0;
  logic [14:0] last_addr = '0;
  always @(negedge clock) begin
    if (spr_we) begin
      if (spr_addr !== exp_base + 15'(wr_cnt - wr_start) ||
          spr_wdata !== 8'(wr_cnt - wr_start))
        wr_bad++;
      last_addr = spr_addr;
      wr_cnt++;
    end
  end

  logic [47:0] rx_q[$];
  int          rx_start = 0;
  always @(negedge clock) begin
    if (draw_valid && draw_ready) rx_q.push_back({draw_sprite, draw_x, draw_y, draw_flags});
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] cmd, input logic [15:0] idx, input logic [7:0] data,
                      input bit rdy_last = 1'b0);
    @(posedge clock); #1;
    in_byte = 1'b1;
    @(posedge clock); #1;
    in_byte    = 1'b0;
    in_command = cmd;
    in_index   = idx;
    in_data    = data;
    if (rdy_last) draw_ready = 1'b1;
  endtask

  task automatic send_draw(input logic [7:0] sp, input logic [15:0] x, input logic [15:0] y,
                           input logic [7:0] fl, input bit rdy_last = 1'b0);
    send(COMMAND_DRAW_SPRITE, 16'd0, COMMAND_DRAW_SPRITE);
    send(COMMAND_DRAW_SPRITE, 16'd1, sp);
    send(COMMAND_DRAW_SPRITE, 16'd2, x[15:8]);
    send(COMMAND_DRAW_SPRITE, 16'd3, x[7:0]);
    send(COMMAND_DRAW_SPRITE, 16'd4, y[15:8]);
    send(COMMAND_DRAW_SPRITE, 16'd5, y[7:0]);
    send(COMMAND_DRAW_SPRITE, 16'd6, fl, rdy_last);
  endtask

  task automatic send_save(input logic [7:0] id, input int npix);
    send(COMMAND_SAVE_SPRITE, 16'd0, COMMAND_SAVE_SPRITE);
    send(COMMAND_SAVE_SPRITE, 16'd1, id);
    for (int i = 0; i < npix; i++) send(COMMAND_SAVE_SPRITE, 16'(i + 2), 8'(i));
  endtask

  function automatic logic [47:0] ent(input int k);
    return {8'(k), 16'(16'h0100 + k), 16'(16'h0200 + k), 8'(k) ^ 8'hA5};
  endfunction

  task automatic check_rx(input string tag, input int k, input logic [47:0] exp);
    if (rx_q.size() > rx_start + k) check(tag, 64'(rx_q[rx_start + k]), 64'(exp));
    else                            check(tag, 64'hDEAD, 64'(exp));
  endtask

  initial begin
    idle(3);
    reset = 1'b0;
    #1;
    check("rst_we",       64'(spr_we),        64'd0);
    check("rst_addr",     64'(spr_addr),      64'd0);
    check("rst_wdata",    64'(spr_wdata),     64'd0);
    check("rst_valid",    64'(draw_valid),    64'd0);
    check("rst_overflow", 64'(draw_overflow), 64'd0);

    // Full sprite 3: addresses 0x600..0x7FF, data 00..FF twice.
    exp_base = 15'h600; wr_start = wr_cnt; wr_bad = 0;
    send_save(8'd3, 512);
    idle(3);
    check("save3_count", 64'(wr_cnt - wr_start), 64'd512);
    check("save3_bad",   64'(wr_bad),            64'd0);
    check("save3_last",  64'(last_addr),         64'h7FF);
    check("save3_idle",  64'(dut.state),         64'(ST_IDLE));
    send(COMMAND_SAVE_SPRITE, 16'd514, 8'h55);
    idle(3);
    check("save3_past_end", 64'(wr_cnt - wr_start), 64'd512);

    // Out-of-range id 200 is ignored; a following DRAW still decodes.
    wr_start = wr_cnt;
    send_save(8'd200, 8);
    idle(3);
    check("save200_count", 64'(wr_cnt - wr_start), 64'd0);
    draw_ready = 1'b1; rx_start = rx_q.size();
    send_draw(8'h05, 16'h0140, 16'h00F0, 8'h02);
    idle(4);
    check("draw1_count", 64'(rx_q.size() - rx_start), 64'd1);
    check_rx("draw1_entry", 0, 48'h05_0140_00F0_02);
    check("draw1_empty", 64'(draw_valid), 64'd0);

    // Fill to 8, then a push coincident with a pop, then one true drop.
    draw_ready = 1'b0; rx_start = rx_q.size();
    for (int k = 0; k < 8; k++) send_draw(ent(k)[47:40], ent(k)[39:24], ent(k)[23:8], ent(k)[7:0]);
    idle(3);
    check("fill_valid",    64'(draw_valid),    64'd1);
    check("fill_overflow", 64'(draw_overflow), 64'd0);
    send_draw(ent(8)[47:40], ent(8)[39:24], ent(8)[23:8], ent(8)[7:0], 1'b1);
    @(posedge clock); #1;
    draw_ready = 1'b0;
    idle(2);
    check("pushpop_overflow", 64'(draw_overflow), 64'd0);
    send_draw(8'hEE, 16'hEEEE, 16'hEEEE, 8'hEE);
    idle(3);
    check("drop_overflow", 64'(draw_overflow), 64'd1);
    draw_ready = 1'b1;
    idle(12);
    draw_ready = 1'b0;
    check("drain_count", 64'(rx_q.size() - rx_start), 64'd9);
    for (int k = 0; k < 9; k++) check_rx($sformatf("drain_%0d", k), k, ent(k));
    check("drain_empty",     64'(draw_valid),    64'd0);
    check("sticky_overflow", 64'(draw_overflow), 64'd1);

    // Partial DRAW cut by frame_end, then a full DRAW.
    draw_ready = 1'b1; rx_start = rx_q.size();
    send(COMMAND_DRAW_SPRITE, 16'd0, COMMAND_DRAW_SPRITE);
    send(COMMAND_DRAW_SPRITE, 16'd1, 8'h77);
    send(COMMAND_DRAW_SPRITE, 16'd2, 8'h88);
    @(posedge clock); #1; frame_end = 1'b1;
    @(posedge clock); #1; frame_end = 1'b0;
    check("fe_idle", 64'(dut.state), 64'(ST_IDLE));
    send_draw(8'h11, 16'h2233, 16'h4455, 8'h66);
    idle(4);
    check("fe_count", 64'(rx_q.size() - rx_start), 64'd1);
    check_rx("fe_entry", 0, 48'h11_2233_4455_66);

    // Index gap aborts the DRAW.
    rx_start = rx_q.size();
    send(COMMAND_DRAW_SPRITE, 16'd0, COMMAND_DRAW_SPRITE);
    send(COMMAND_DRAW_SPRITE, 16'd1, 8'h01);
    send(COMMAND_DRAW_SPRITE, 16'd2, 8'h02);
    send(COMMAND_DRAW_SPRITE, 16'd4, 8'h04);
    send(COMMAND_DRAW_SPRITE, 16'd5, 8'h05);
    send(COMMAND_DRAW_SPRITE, 16'd6, 8'h06);
    idle(4);
    check("gap_count", 64'(rx_q.size() - rx_start), 64'd0);

    // Unknown command, then a normal SAVE of sprite 1.
    wr_start = wr_cnt; rx_start = rx_q.size();
    for (int i = 0; i < 5; i++) send(8'h7E, 16'(i), 8'(8'h30 + i));
    idle(3);
    check("unk_writes", 64'(wr_cnt - wr_start),          64'd0);
    check("unk_draws",  64'(rx_q.size() - rx_start),     64'd0);
    exp_base = 15'h200; wr_bad = 0;
    send_save(8'd1, 512);
    idle(3);
    check("save1_count", 64'(wr_cnt - wr_start), 64'd512);
    check("save1_bad",   64'(wr_bad),            64'd0);
    check("save1_last",  64'(last_addr),         64'h3FF);

`ifdef SPI_EXEC_STATS_EN
    check("stat_writes", 64'(stat_writes), 64'd1024);
    check("stat_draws",  64'(stat_draws),  64'd11);
    check("stat_drops",  64'(stat_drops),  64'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
